// File: rtl/masked_merge_pipe_pkg.sv
// Shared types and constants for the masked_merge_pipe datapath.
// Contents: the mode_e enum, the transaction counter width and saturation value,
// and a helper that folds the reserved mode onto PASS.
package mmp_pkg;

    // Per-beat output mode. The reserved encoding behaves exactly like PASS.
    typedef enum logic [1:0] {
        MMP_PASS  = 2'd0,
        MMP_ACC   = 2'd1,
        MMP_MERGE = 2'd2,
        MMP_RSVD  = 2'd3
    } mode_e;

    localparam int                   MMP_CNT_W   = 16;
    localparam logic [MMP_CNT_W-1:0] MMP_CNT_MAX = {MMP_CNT_W{1'b1}};

    // Maps the reserved encoding onto PASS so that downstream decode has three cases.
    function automatic mode_e mmp_norm_mode(input logic [1:0] raw);
        mode_e m;
        m = mode_e'(raw);
        return (m == MMP_RSVD) ? MMP_PASS : m;
    endfunction

endpackage : mmp_pkg

// File: rtl/masked_merge_pipe_slice.sv
// mmp_slice: a single-entry valid/ready pipeline register with a
// parametrised payload width.
// It accepts a new word whenever it is empty or its content leaves on the same edge.
// The ready output depends only on the slice's own state and downstream ready,
// never on i_valid.
module mmp_slice #(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [PW-1:0] i_data,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [PW-1:0] o_data
);

    logic          r_valid;
    logic [PW-1:0] r_data;

    // Accept when empty or when the held word is being taken this cycle.
    assign o_ready = !r_valid || i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    // Occupancy flag: follows the input valid whenever the slice can accept.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments, so every flop samples
        // pre-edge values and the simulation order of the processes does not matter.
        if (rst) begin
            r_valid <= 1'b0;
        end else if (o_ready) begin
            r_valid <= i_valid;
        end
    end

    // Payload capture on a handshake.
    // NOTE: the payload is deliberately left unreset. r_valid qualifies it, so
    // resetting it would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (i_valid && o_ready) begin
            r_data <= i_data;
        end
    end

endmodule : mmp_slice

// File: rtl/masked_merge_pipe.sv
// masked_merge_pipe: a two-stage pipelined masked-AND datapath with PASS,
// OR-accumulate and MERGE output modes behind a valid/ready handshake.
//
// Stage 1 is an mmp_slice that carries {mode, d, r}, with d = a & (b|c) and r = a & b.
// Stage 2 is inline. It holds the mode mux, the accumulator and the output register.
//
// Optional feature: define MASKED_MERGE_PIPE_TXN_CNT_EN to build a saturating
// 16-bit count of accepted outputs. Without it, txn_cnt is tied to zero.
module masked_merge_pipe
    import mmp_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int SPLIT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [WIDTH-1:0]     c,
    input  logic [1:0]           mode,
    input  logic                 acc_clr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     q,
    output logic [MMP_CNT_W-1:0] txn_cnt
);

    // Stage-1 payload layout: {mode[1:0], d[WIDTH-1:0], r[WIDTH-1:0]}.
    localparam int PW = 2 + 2 * WIDTH;

    // Illegal geometries would make the merge fields overlap or vanish.
    if (WIDTH < 2 || SPLIT < 1 || SPLIT > WIDTH - 1) begin : g_bad_params
        $error("masked_merge_pipe: need WIDTH>=2 and 1<=SPLIT<=WIDTH-1");
    end

    logic [WIDTH-1:0] w_d_in;
    logic [WIDTH-1:0] w_r_in;
    logic [PW-1:0]    w_s1_in;
    logic             w_s1_in_ready;
    logic             w_s1_valid;
    logic [PW-1:0]    w_s1_data;
    logic             w_s2_ready;
    logic             w_s2_load;
    mode_e            w_s1_mode;
    logic [WIDTH-1:0] w_s1_d;
    logic [WIDTH-1:0] w_s1_r;
    logic [WIDTH-1:0] w_merged;
    logic [WIDTH-1:0] w_acc_base;
    logic [WIDTH-1:0] w_q_next;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_acc;

    // Operand reduction happens before stage 1, so the slice holds only the two
    // results that are needed.
    assign w_d_in  = a & (b | c);
    assign w_r_in  = a & b;
    assign w_s1_in = {mode, w_d_in, w_r_in};

    // Stage 2 can take a word when it is empty or its result is leaving now.
    assign w_s2_ready = !r_out_valid || out_ready;
    assign w_s2_load  = w_s1_valid && w_s2_ready;

    mmp_slice #(
        .PW (PW)
    ) u_stage1 (
        .clk     (clk),
        .rst     (rst),
        .i_valid (in_valid),
        .o_ready (w_s1_in_ready),
        .i_data  (w_s1_in),
        .o_valid (w_s1_valid),
        .i_ready (w_s2_ready),
        .o_data  (w_s1_data)
    );

    // in_ready stays low while rst is asserted. Otherwise it equals
    // !s1_valid || !out_valid || out_ready.
    assign in_ready = !rst && w_s1_in_ready;

    assign w_s1_mode = mmp_norm_mode(w_s1_data[PW-1 -: 2]);
    assign w_s1_d    = w_s1_data[2*WIDTH-1 -: WIDTH];
    assign w_s1_r    = w_s1_data[WIDTH-1:0];

    // Each merged bit has a single source: r above the split and d below it.
    assign w_merged = {w_s1_r[WIDTH-1:SPLIT], w_s1_d[SPLIT-1:0]};

    // A clear in the same cycle as an ACC load takes effect first.
    assign w_acc_base = acc_clr ? '0 : r_acc;

    // Next result selected by the mode captured with the beat.
    always_comb begin
        // NOTE: default assignment first, so no path through this block can infer a latch.
        w_q_next = w_s1_d;
        unique case (w_s1_mode)
            MMP_ACC:   w_q_next = w_acc_base | w_s1_d;
            MMP_MERGE: w_q_next = w_merged;
            default:   w_q_next = w_s1_d;
        endcase
    end

    // Output stage: it loads on a stage-2 handshake and holds while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_q         <= '0;
        end else if (w_s2_load) begin
            r_out_valid <= 1'b1;
            r_q         <= w_q_next;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Accumulator: an ACC load ORs d into it. A standalone acc_clr zeroes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (w_s2_load && w_s1_mode == MMP_ACC) begin
            r_acc <= w_q_next;
        end else if (acc_clr) begin
            r_acc <= '0;
        end
    end

    assign out_valid = r_out_valid;
    assign q         = r_q;

`ifdef MASKED_MERGE_PIPE_TXN_CNT_EN
    logic [MMP_CNT_W-1:0] r_txn_cnt;

    // Saturating count of results taken downstream. acc_clr does not clear it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_txn_cnt <= '0;
        end else if (r_out_valid && out_ready && r_txn_cnt != MMP_CNT_MAX) begin
            r_txn_cnt <= r_txn_cnt + 1'b1;
        end
    end

    assign txn_cnt = r_txn_cnt;
`else
    assign txn_cnt = '0;
`endif

endmodule : masked_merge_pipe

// File: tb/tb_masked_merge_pipe.sv
// Directed self-checking bench for masked_merge_pipe at WIDTH=4 and SPLIT=2.
// The bench drives inputs and samples outputs on the falling clock edge.
// Build with MASKED_MERGE_PIPE_TXN_CNT_EN to exercise the transaction counter.
module tb_masked_merge_pipe;
    import mmp_pkg::*;

    localparam int WIDTH = 4;
    localparam int SPLIT = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a, b, c;
    logic [1:0]           mode;
    logic                 acc_clr;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     q;
    logic [MMP_CNT_W-1:0] txn_cnt;

    int n_vec  = 0;
    int n_miss = 0;

    masked_merge_pipe #(
        .WIDTH (WIDTH),
        .SPLIT (SPLIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .mode      (mode),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .txn_cnt   (txn_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Applies one beat to an empty pipe with out_ready=1 and checks the
    // two-cycle latency and the result. Optionally pulses acc_clr in the
    // stage-2 load cycle.
    task automatic run_single(input string tag, input logic [3:0] ia, input logic [3:0] ib,
                              input logic [3:0] ic, input logic [1:0] im, input logic clr,
                              input logic [3:0] exp);
        a = ia; b = ib; c = ic; mode = im; in_valid = 1'b1; out_ready = 1'b1;
        #1 check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        acc_clr  = clr;
        check({tag, "_lat1_valid"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        acc_clr = 1'b0;
        check({tag, "_lat2_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_q"}, 32'(q), 32'(exp));
    endtask

    logic [3:0] bp_exp [4];
    int nin, nout;

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; c = '0;
        mode = MMP_PASS; acc_clr = 1'b0; out_ready = 1'b1;
        bp_exp[0] = 4'h1; bp_exp[1] = 4'h2; bp_exp[2] = 4'h3; bp_exp[3] = 4'h4;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_q", 32'(q), 32'd0);
        check("rst_txn_cnt", 32'(txn_cnt), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // PASS: d = F & (3|4) = 7
        run_single("pass", 4'hF, 4'h3, 4'h4, MMP_PASS, 1'b0, 4'h7);
        // MERGE: d=D r=C -> {11,01}=D ; d=3 r=3 -> {00,11}=3
        run_single("merge1", 4'hF, 4'hC, 4'h1, MMP_MERGE, 1'b0, 4'hD);
        run_single("merge2", 4'hF, 4'h3, 4'h0, MMP_MERGE, 1'b0, 4'h3);
        // ACC: 1, 1|4=5, 5|8=D, then clear in the same cycle as d=2 -> 2
        run_single("acc1", 4'hF, 4'h1, 4'h0, MMP_ACC, 1'b0, 4'h1);
        run_single("acc2", 4'hF, 4'h4, 4'h0, MMP_ACC, 1'b0, 4'h5);
        run_single("acc3", 4'hF, 4'h8, 4'h0, MMP_ACC, 1'b0, 4'hD);
        run_single("acc_clr_load", 4'hF, 4'h2, 4'h0, MMP_ACC, 1'b1, 4'h2);
        // Reserved mode acts as PASS: d = F & (0|5) = 5
        run_single("rsvd", 4'hF, 4'h0, 4'h5, MMP_RSVD, 1'b0, 4'h5);
        // acc_clr during a MERGE load leaves the merged result intact
        run_single("merge_clr", 4'hF, 4'hC, 4'h1, MMP_MERGE, 1'b1, 4'hD);

        // Backpressure: 4 PASS beats with out_ready low in cycles 1..3
        @(negedge clk);
        nin = 0; nout = 0;
        for (int cyc = 0; cyc < 30 && nout < 4; cyc++) begin
            out_ready = !(cyc >= 1 && cyc <= 3);
            in_valid  = (nin < 4);
            a = 4'hF; c = 4'h0; mode = MMP_PASS;
            b = (nin < 4) ? bp_exp[nin] : 4'h0;
            #1;
            if (cyc == 2 || cyc == 3) begin
                check("bp_in_ready_low", 32'(in_ready), 32'd0);
                check("bp_out_valid_hold", 32'(out_valid), 32'd1);
                check("bp_q_hold", 32'(q), 32'(bp_exp[0]));
            end
            if (out_valid && out_ready) begin
                check("bp_order", 32'(q), 32'(bp_exp[nout]));
                nout++;
            end
            if (in_valid && in_ready) nin++;
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("bp_accepted", 32'(nin), 32'd4);
        check("bp_delivered", 32'(nout), 32'd4);
        check("bp_no_dup0", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("bp_no_dup1", 32'(out_valid), 32'd0);

        // Reset with both stages full (ACC beats d=3, d=5, stalled)
        mode = MMP_ACC; out_ready = 1'b0; a = 4'hF; c = 4'h0;
        b = 4'h3; in_valid = 1'b1;
        @(negedge clk);
        b = 4'h5;
        @(negedge clk);
        in_valid = 1'b0;
        check("full_out_valid", 32'(out_valid), 32'd1);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_q", 32'(q), 32'd3);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_q", 32'(q), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("midrst_dropped", 32'(out_valid), 32'd0);
        // acc was cleared: 0|6 = 6 (not 3|6 = 7)
        run_single("acc_after_rst", 4'hF, 4'h6, 4'h0, MMP_ACC, 1'b0, 4'h6);
        @(negedge clk);

`ifdef MASKED_MERGE_PIPE_TXN_CNT_EN
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            run_single("cnt_beat", 4'hF, 4'h1, 4'h0, MMP_PASS, 1'b0, 4'h1);
        end
        @(negedge clk);
        check("txn_cnt_5", 32'(txn_cnt), 32'd5);
        dut.r_txn_cnt = 16'hFFFE;
        for (int i = 0; i < 3; i++) begin
            run_single("sat_beat", 4'hF, 4'h2, 4'h0, MMP_PASS, 1'b0, 4'h2);
        end
        @(negedge clk);
        check("txn_cnt_sat", 32'(txn_cnt), 32'hFFFF);
`else
        check("txn_cnt_tied", 32'(txn_cnt), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_masked_merge_pipe
